// File: rtl/jtbubl_snd_pkg.sv
// Shared definitions for the sound mailbox: register offsets, status byte layout and NMI states.
package jtbubl_snd_pkg;

   typedef logic [7:0] byte_t;

   localparam logic [1:0] REG_CMD   = 2'd0;
   localparam logic [1:0] REG_STAT  = 2'd1;
   localparam logic [1:0] REG_REPLY = 2'd2;
   localparam logic [1:0] REG_NMI   = 2'd3;

   localparam int STAT_OVF   = 7;
   localparam int STAT_PEND  = 6;
   localparam int STAT_CNT_W = 3;

   typedef enum logic [1:0] {
      NMI_IDLE  = 2'd0,
      NMI_PULSE = 2'd1,
      NMI_WAIT  = 2'd2
   } nmi_st_e;

   // Unused status bits read back as 1 so the byte looks like an open-bus value around the count.
   function automatic byte_t status_byte(input logic ovf, input logic pend,
                                         input logic [STAT_CNT_W-1:0] cnt);
      byte_t s;
      s = 8'hFF;
      s[STAT_OVF]          = ovf;
      s[STAT_PEND]         = pend;
      s[STAT_CNT_W-1:0]    = cnt;
      return s;
   endfunction

endpackage

// File: rtl/jtbubl_snd_mbox_if.sv
// Mailbox bus: main-CPU command/reply handshake plus the sound-CPU I/O access signals.
interface jtbubl_snd_mbox_if;
   import jtbubl_snd_pkg::*;

   byte_t      main_din;
   logic       main_wr;
   logic       main_full;
   logic       main_rd;
   byte_t      main_dout;
   logic       main_stb;
   logic       reply_pend;
   logic       io_cs;
   logic       rd_n;
   logic       wr_n;
   logic [1:0] addr;
   byte_t      cpu_dout;
   byte_t      io_dout;
   logic       nmi_n;

   modport master (
      output main_din, main_wr, main_rd, io_cs, rd_n, wr_n, addr, cpu_dout,
      input  main_full, main_dout, main_stb, reply_pend, io_dout, nmi_n
   );

   modport slave (
      input  main_din, main_wr, main_rd, io_cs, rd_n, wr_n, addr, cpu_dout,
      output main_full, main_dout, main_stb, reply_pend, io_dout, nmi_n
   );
endinterface

// File: rtl/jtbubl_snd_fifo.sv
// Small synchronous FIFO; a pop frees a slot in the same clk so a push while full can still land.
module jtbubl_snd_fifo #(
   parameter int AW     = 2,
   parameter int DATA_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty
);
   logic [DATA_W-1:0] mem_q [2**AW];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q, count_d;
   logic              push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == {1'b1, {AW{1'b0}}});
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/jtbubl_snd_mbox.sv
// Main->sound command mailbox: access edge detection, register map, reply latch and NMI pulse FSM.
module jtbubl_snd_mbox
   import jtbubl_snd_pkg::*;
#(
   parameter int AW      = 2,
   parameter int NMI_LEN = 8
)(
   input  logic             snd_rstn,
   input  logic             clk,
   input  logic             cen3,
   jtbubl_snd_mbox_if.slave bus
);
   logic        rd_n_q, wr_n_q, rd_act_q, rd_pop_q;
   logic [1:0]  rd_addr_q;
   logic        ovf_q, reply_pend_q, main_stb_q, nmi_en_q, nmi_n_q;
   byte_t       io_dout_q, main_dout_q;
   logic [7:0]  nmi_tmr_q;
   nmi_st_e     nmi_st_q;

   logic        rd_start, rd_end, wr_start;
   logic        fifo_pop, fifo_full, fifo_empty, overflow;
   byte_t       fifo_head;
   logic [AW:0] fifo_count;

   // An access acts once: start on the strobe's falling edge, end when a tracked read releases rd_n.
   assign rd_start = bus.io_cs & ~bus.rd_n & rd_n_q;
   assign rd_end   = rd_act_q & bus.rd_n;
   assign wr_start = bus.io_cs & ~bus.wr_n & wr_n_q;
   assign fifo_pop = rd_end & rd_pop_q;
   assign overflow = bus.main_wr & fifo_full & ~fifo_pop;

   jtbubl_snd_fifo #(.AW(AW), .DATA_W(8)) u_fifo (
      .clk   (clk),
      .rst_n (snd_rstn),
      .push  (bus.main_wr),
      .pop   (fifo_pop),
      .din   (bus.main_din),
      .dout  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge snd_rstn) begin
      if (!snd_rstn) begin
         rd_n_q       <= 1'b1;
         wr_n_q       <= 1'b1;
         rd_act_q     <= 1'b0;
         rd_pop_q     <= 1'b0;
         rd_addr_q    <= REG_CMD;
         io_dout_q    <= 8'hFF;
         main_dout_q  <= 8'h00;
         main_stb_q   <= 1'b0;
         reply_pend_q <= 1'b0;
         ovf_q        <= 1'b0;
         nmi_en_q     <= 1'b0;
      end else begin
         rd_n_q <= bus.rd_n;
         wr_n_q <= bus.wr_n;
         if (rd_start) begin
            rd_act_q  <= 1'b1;
            rd_addr_q <= bus.addr;
            rd_pop_q  <= 1'b0;
            case (bus.addr)
               REG_CMD: begin
                  // Pop is deferred to read end so io_dout stays stable for the whole access.
                  if (!fifo_empty) begin
                     io_dout_q <= fifo_head;
                     rd_pop_q  <= 1'b1;
                  end
               end
               REG_STAT: io_dout_q <= status_byte(ovf_q, reply_pend_q, STAT_CNT_W'(fifo_count));
               default:  io_dout_q <= 8'hFF;
            endcase
         end else if (rd_end) begin
            rd_act_q <= 1'b0;
            rd_pop_q <= 1'b0;
         end
         if (overflow)                            ovf_q <= 1'b1;
         else if (rd_end && rd_addr_q == REG_STAT) ovf_q <= 1'b0;
         main_stb_q <= 1'b0;
         if (wr_start && bus.addr == REG_REPLY) begin
            main_dout_q  <= bus.cpu_dout;
            reply_pend_q <= 1'b1;
            main_stb_q   <= 1'b1;
         end else if (bus.main_rd) begin
            reply_pend_q <= 1'b0;
         end
         if (wr_start && bus.addr == REG_NMI) nmi_en_q <= bus.cpu_dout[0];
      end
   end

   // WAIT holds nmi_n high until the Z80 consumes a command, so every pulse maps to one byte.
   always_ff @(posedge clk or negedge snd_rstn) begin
      if (!snd_rstn) begin
         nmi_st_q  <= NMI_IDLE;
         nmi_tmr_q <= 8'd0;
         nmi_n_q   <= 1'b1;
      end else begin
         case (nmi_st_q)
            NMI_IDLE: begin
               if (nmi_en_q && !fifo_empty) begin
                  nmi_st_q  <= NMI_PULSE;
                  nmi_tmr_q <= 8'(NMI_LEN);
                  nmi_n_q   <= 1'b0;
               end
            end
            NMI_PULSE: begin
               if (!nmi_en_q) begin
                  nmi_n_q  <= 1'b1;
                  nmi_st_q <= NMI_IDLE;
               end else if (cen3) begin
                  nmi_tmr_q <= nmi_tmr_q - 8'd1;
                  if (nmi_tmr_q == 8'd1) begin
                     nmi_n_q  <= 1'b1;
                     nmi_st_q <= NMI_WAIT;
                  end
               end
            end
            NMI_WAIT: begin
               if (fifo_pop || !nmi_en_q) nmi_st_q <= NMI_IDLE;
            end
            default: begin
               nmi_st_q <= NMI_IDLE;
               nmi_n_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.main_full  = fifo_full;
   assign bus.main_dout  = main_dout_q;
   assign bus.main_stb   = main_stb_q;
   assign bus.reply_pend = reply_pend_q;
   assign bus.io_dout    = io_dout_q;
   assign bus.nmi_n      = nmi_n_q;
endmodule

// File: tb/tb_jtbubl_snd_mbox.sv
// Bench for jtbubl_snd_mbox: queue-based reference model of the mailbox, random and directed scenarios.
module tb_jtbubl_snd_mbox;
   localparam int NMI_LEN = 8;
   localparam int DEPTH   = 4;

   logic clk = 1'b0;
   logic snd_rstn = 1'b0;
   logic cen3 = 1'b0;
   jtbubl_snd_mbox_if mb();

   jtbubl_snd_mbox #(.AW(2), .NMI_LEN(NMI_LEN)) dut (
      .snd_rstn (snd_rstn),
      .clk      (clk),
      .cen3     (cen3),
      .bus      (mb)
   );

   always #5 clk = ~clk;

   initial forever begin
      repeat (3) @(negedge clk);
      cen3 = 1'b1;
      @(negedge clk);
      cen3 = 1'b0;
   end

   // Reference model: command queue, overflow flag, reply pending, last value the CPU read.
   logic [7:0] q[$];
   logic       ovf_m = 1'b0;
   logic       pend_m = 1'b0;
   logic [7:0] last_io = 8'hFF;
   int n_chk = 0;
   int n_pass = 0;

   function automatic logic [7:0] exp_status();
      logic [2:0] c;
      c = 3'(q.size());
      return {ovf_m, pend_m, 3'b111, c};
   endfunction

   task automatic model_read(input logic [1:0] a, output logic [7:0] e);
      case (a)
         2'd0: if (q.size() != 0) e = q.pop_front(); else e = last_io;
         2'd1: begin e = exp_status(); ovf_m = 1'b0; end
         default: e = 8'hFF;
      endcase
      last_io = e;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] d);
      @(negedge clk); mb.main_din = d; mb.main_wr = 1'b1;
      @(negedge clk); mb.main_wr = 1'b0;
      if (q.size() < DEPTH) q.push_back(d); else ovf_m = 1'b1;
   endtask

   task automatic cpu_read(input logic [1:0] a, input int hold, output logic [7:0] d, output logic stable);
      @(negedge clk); mb.io_cs = 1'b1; mb.addr = a; mb.rd_n = 1'b0;
      @(negedge clk); d = mb.io_dout; stable = 1'b1;
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         if (mb.io_dout !== d) stable = 1'b0;
      end
      mb.rd_n = 1'b1;
      @(negedge clk); mb.io_cs = 1'b0;
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk); mb.io_cs = 1'b1; mb.addr = a; mb.cpu_dout = d; mb.wr_n = 1'b0;
      @(negedge clk); mb.wr_n = 1'b1; mb.io_cs = 1'b0;
      if (a == 2'd2) pend_m = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] d, e;
      logic st;
      snd_rstn = 1'b0;
      tick(3);
      n_chk++; if (mb.nmi_n !== 1'b1) $display("FAIL rst_nmi_n got %b want 1", mb.nmi_n); else n_pass++;
      n_chk++; if (mb.io_dout !== 8'hFF) $display("FAIL rst_io_dout got %h want ff", mb.io_dout); else n_pass++;
      n_chk++; if (mb.main_dout !== 8'h00) $display("FAIL rst_main_dout got %h want 00", mb.main_dout); else n_pass++;
      n_chk++; if ({mb.main_stb, mb.reply_pend, mb.main_full} !== 3'b000)
         $display("FAIL rst_flags got %b want 000", {mb.main_stb, mb.reply_pend, mb.main_full}); else n_pass++;
      @(negedge clk); snd_rstn = 1'b1;
      tick(2);
      model_read(2'd1, e);
      cpu_read(2'd1, 1, d, st);
      n_chk++; if (d !== e) $display("FAIL rst_status got %h want %h", d, e); else n_pass++;
   endtask

   task automatic test_nmi_pulse();
      logic [7:0] d, e;
      logic st, done, bad;
      int ticks;
      cpu_write(2'd3, 8'h01);
      @(negedge clk); mb.main_din = 8'h5A; mb.main_wr = 1'b1;
      @(negedge clk); mb.main_wr = 1'b0; q.push_back(8'h5A);
      n_chk++; if (mb.nmi_n !== 1'b1) $display("FAIL nmi_lat1 got %b want 1", mb.nmi_n); else n_pass++;
      @(negedge clk);
      n_chk++; if (mb.nmi_n !== 1'b0) $display("FAIL nmi_lat2 got %b want 0", mb.nmi_n); else n_pass++;
      ticks = 0; done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk);
         if (cen3) ticks++;
         #1;
         if (mb.nmi_n) done = 1'b1;
      end
      n_chk++; if (!done || ticks != NMI_LEN)
         $display("FAIL nmi_len got %0d ticks (ended=%b) want %0d", ticks, done, NMI_LEN); else n_pass++;
      model_read(2'd0, e);
      cpu_read(2'd0, 2, d, st);
      n_chk++; if (d !== e) $display("FAIL nmi_cmd got %h want %h", d, e); else n_pass++;
      model_read(2'd1, e);
      cpu_read(2'd1, 1, d, st);
      n_chk++; if (d !== e) $display("FAIL nmi_stat got %h want %h", d, e); else n_pass++;
      bad = 1'b0;
      repeat (40) begin @(negedge clk); if (!mb.nmi_n) bad = 1'b1; end
      n_chk++; if (bad) $display("FAIL nmi_repulse got low want high"); else n_pass++;
      cpu_write(2'd3, 8'h00);
   endtask

   task automatic test_overflow();
      logic [7:0] d, e;
      logic st;
      for (int i = 1; i <= 5; i++) begin
         push(8'(i));
         if (i >= 4) begin
            n_chk++; if (mb.main_full !== 1'b1) $display("FAIL ovf_full%0d got %b want 1", i, mb.main_full); else n_pass++;
         end
      end
      for (int k = 0; k < 2; k++) begin
         model_read(2'd1, e);
         cpu_read(2'd1, 1, d, st);
         n_chk++; if (d !== e) $display("FAIL ovf_stat%0d got %h want %h", k, d, e); else n_pass++;
      end
      for (int k = 0; k < 4; k++) begin
         model_read(2'd0, e);
         cpu_read(2'd0, 1, d, st);
         n_chk++; if (d !== e) $display("FAIL ovf_cmd%0d got %h want %h", k, d, e); else n_pass++;
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] d, e, nb;
      logic st;
      for (int k = 0; k < 4; k++) push(8'($urandom));
      n_chk++; if (mb.main_full !== 1'b1) $display("FAIL fpp_full got %b want 1", mb.main_full); else n_pass++;
      nb = 8'($urandom);
      model_read(2'd0, e);
      @(negedge clk); mb.io_cs = 1'b1; mb.addr = 2'd0; mb.rd_n = 1'b0;
      @(negedge clk); d = mb.io_dout;
      @(negedge clk); mb.rd_n = 1'b1; mb.main_din = nb; mb.main_wr = 1'b1;
      @(negedge clk); mb.main_wr = 1'b0; mb.io_cs = 1'b0;
      q.push_back(nb);
      n_chk++; if (d !== e) $display("FAIL fpp_cmd got %h want %h", d, e); else n_pass++;
      n_chk++; if (mb.main_full !== 1'b1) $display("FAIL fpp_full2 got %b want 1", mb.main_full); else n_pass++;
      model_read(2'd1, e);
      cpu_read(2'd1, 1, d, st);
      n_chk++; if (d !== e) $display("FAIL fpp_stat got %h want %h", d, e); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         model_read(2'd0, e);
         cpu_read(2'd0, 1, d, st);
         n_chk++; if (d !== e) $display("FAIL fpp_drain%0d got %h want %h", k, d, e); else n_pass++;
      end
   endtask

   task automatic test_long_read();
      logic [7:0] d, e;
      logic st;
      push(8'($urandom));
      push(8'($urandom));
      model_read(2'd0, e);
      cpu_read(2'd0, 20, d, st);
      n_chk++; if (d !== e) $display("FAIL long_cmd got %h want %h", d, e); else n_pass++;
      n_chk++; if (st !== 1'b1) $display("FAIL long_stable got %b want 1", st); else n_pass++;
      model_read(2'd1, e);
      cpu_read(2'd1, 1, d, st);
      n_chk++; if (d !== e) $display("FAIL long_stat got %h want %h", d, e); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         model_read(2'd0, e);
         cpu_read(2'd0, 3, d, st);
         n_chk++; if (d !== e) $display("FAIL long_cmd%0d got %h want %h", k, d, e); else n_pass++;
      end
      model_read(2'd1, e);
      cpu_read(2'd1, 1, d, st);
      n_chk++; if (d !== e) $display("FAIL long_stat_empty got %h want %h", d, e); else n_pass++;
   endtask

   task automatic test_reply();
      logic [7:0] d, e, v;
      logic st;
      cpu_write(2'd2, 8'hC3);
      n_chk++; if (mb.main_stb !== 1'b1) $display("FAIL rep_stb got %b want 1", mb.main_stb); else n_pass++;
      n_chk++; if (mb.main_dout !== 8'hC3) $display("FAIL rep_dout got %h want c3", mb.main_dout); else n_pass++;
      n_chk++; if (mb.reply_pend !== 1'b1) $display("FAIL rep_pend got %b want 1", mb.reply_pend); else n_pass++;
      @(negedge clk);
      n_chk++; if (mb.main_stb !== 1'b0) $display("FAIL rep_stb_len got %b want 0", mb.main_stb); else n_pass++;
      @(negedge clk); mb.main_rd = 1'b1;
      @(negedge clk); mb.main_rd = 1'b0; pend_m = 1'b0;
      n_chk++; if (mb.reply_pend !== 1'b0) $display("FAIL rep_ack got %b want 0", mb.reply_pend); else n_pass++;
      v = 8'($urandom);
      @(negedge clk); mb.io_cs = 1'b1; mb.addr = 2'd2; mb.cpu_dout = v; mb.wr_n = 1'b0; mb.main_rd = 1'b1;
      @(negedge clk); mb.wr_n = 1'b1; mb.io_cs = 1'b0; mb.main_rd = 1'b0; pend_m = 1'b1;
      n_chk++; if (mb.reply_pend !== 1'b1) $display("FAIL rep_race got %b want 1", mb.reply_pend); else n_pass++;
      n_chk++; if (mb.main_dout !== v) $display("FAIL rep_race_dout got %h want %h", mb.main_dout, v); else n_pass++;
      model_read(2'd1, e);
      cpu_read(2'd1, 1, d, st);
      n_chk++; if (d !== e) $display("FAIL rep_stat got %h want %h", d, e); else n_pass++;
      @(negedge clk); mb.main_rd = 1'b1;
      @(negedge clk); mb.main_rd = 1'b0; pend_m = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] d, e, v;
      logic [1:0] a;
      logic st;
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 6))
            0, 1: push(8'($urandom));
            2, 3: begin
               a = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
               model_read(a, e);
               cpu_read(a, $urandom_range(1, 4), d, st);
               n_chk++; if (d !== e || !st) $display("FAIL rnd_rd%0d a=%0d got %h/%b want %h/1", it, a, d, st, e); else n_pass++;
            end
            4: begin
               v = 8'($urandom);
               cpu_write(2'd2, v);
               n_chk++; if (mb.main_dout !== v || mb.main_stb !== 1'b1)
                  $display("FAIL rnd_reply%0d got %h/%b want %h/1", it, mb.main_dout, mb.main_stb, v); else n_pass++;
            end
            5: begin
               @(negedge clk); mb.main_rd = 1'b1;
               @(negedge clk); mb.main_rd = 1'b0; pend_m = 1'b0;
               n_chk++; if (mb.reply_pend !== 1'b0) $display("FAIL rnd_ack%0d got %b want 0", it, mb.reply_pend); else n_pass++;
            end
            default: cpu_write(2'($urandom_range(0, 1)), 8'($urandom));
         endcase
         n_chk++; if (mb.main_full !== (q.size() == DEPTH))
            $display("FAIL rnd_full%0d got %b want %b", it, mb.main_full, (q.size() == DEPTH)); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_pulse();
      logic [7:0] d, e;
      logic st, found, bad;
      cpu_write(2'd3, 8'h01);
      push(8'h77);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (!mb.nmi_n) found = 1'b1;
      end
      n_chk++; if (!found) $display("FAIL rmp_pulse got high want low within 20 clk"); else n_pass++;
      tick(2);
      #2 snd_rstn = 1'b0;
      #1;
      n_chk++; if (mb.nmi_n !== 1'b1) $display("FAIL rmp_async got %b want 1", mb.nmi_n); else n_pass++;
      q.delete(); ovf_m = 1'b0; pend_m = 1'b0; last_io = 8'hFF;
      @(negedge clk); snd_rstn = 1'b1;
      @(negedge clk);
      n_chk++; if ({mb.nmi_n, mb.main_stb, mb.reply_pend, mb.main_full} !== 4'b1000)
         $display("FAIL rmp_flags got %b want 1000", {mb.nmi_n, mb.main_stb, mb.reply_pend, mb.main_full}); else n_pass++;
      n_chk++; if (mb.io_dout !== 8'hFF || mb.main_dout !== 8'h00)
         $display("FAIL rmp_data got %h/%h want ff/00", mb.io_dout, mb.main_dout); else n_pass++;
      model_read(2'd1, e);
      cpu_read(2'd1, 1, d, st);
      n_chk++; if (d !== e) $display("FAIL rmp_stat got %h want %h", d, e); else n_pass++;
      push(8'h11);
      bad = 1'b0;
      repeat (10) begin @(negedge clk); if (!mb.nmi_n) bad = 1'b1; end
      n_chk++; if (bad) $display("FAIL rmp_nmi_en got pulse want none"); else n_pass++;
   endtask

   initial begin
      mb.main_din = 8'h00; mb.main_wr = 1'b0; mb.main_rd = 1'b0;
      mb.io_cs = 1'b0; mb.rd_n = 1'b1; mb.wr_n = 1'b1; mb.addr = 2'd0; mb.cpu_dout = 8'h00;
      test_reset();
      test_nmi_pulse();
      test_overflow();
      test_full_push_pop();
      test_long_read();
      test_reply();
      test_random();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
